// File: rtl/cpu_pkg.sv
// Shared decoder definitions: sequencer states, default uop field positions
// and the opcode-forming function used to address the jump ROM.
package cpu_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    JUMP  = 2'd1,
    ULOAD = 2'd2,
    ISSUE = 2'd3
  } dec_state_t;

  localparam int EOL_BIT_DFLT = 4;
  localparam int BR_BIT_DFLT  = 5;
  localparam int BR_LSB_DFLT  = 8;

  // top = {b0, b1}, the two most significant bytes of the instruction
  function automatic logic [7:0] opcode_of(input logic [15:0] top);
    if (top[15:12] == 4'hC)
      return {top[15:12], top[7:4]};
    else if (top[15:12] >= 4'hD)
      return {top[15:10], top[7:6]};
    else
      return {top[15:12], top[9:8], top[1:0]};
  endfunction

endpackage

// File: rtl/decoder_pfbuf.sv
// One-entry prefetch buffer plus the instruction request towards the queue.
// A word accepted in FETCH with the buffer empty bypasses the buffer.
module decoder_pfbuf #(
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_fetch,
  input  logic               aki_n,
  input  logic [INSTR_W-1:0] cmd_n,
  input  logic               drain,
  output logic               rqi_p,
  output logic               direct,
  output logic               buf_vld,
  output logic [INSTR_W-1:0] buf_data
);

  logic fill;

  assign rqi_p  = !rst && (in_fetch || !buf_vld);
  assign direct = rqi_p && aki_n && !flush && in_fetch && !buf_vld;
  assign fill   = rqi_p && aki_n && !flush && !(in_fetch && !buf_vld);

  // A simultaneous fill and drain keeps the buffer full with the new word
  always_ff @(posedge clk) begin
    if (rst || flush)
      buf_vld <= 1'b0;
    else if (fill)
      buf_vld <= 1'b1;
    else if (drain)
      buf_vld <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (fill)
      buf_data <= cmd_n;
  end

endmodule

// File: rtl/decoder_seq.sv
// Instruction decoder sequencer: fetches instructions, looks up their entry
// point in the jump ROM and walks the microcode ROM, issuing one uop at a time.
module decoder_seq
  import cpu_pkg::*;
#(
  parameter int INSTR_W = 32,
  parameter int UADR_W  = 8,
  parameter int UOP_W   = 16,
  parameter int EOL_BIT = EOL_BIT_DFLT,
  parameter int BR_BIT  = BR_BIT_DFLT,
  parameter int BR_LSB  = BR_LSB_DFLT
) (
  input  logic               clk,
  input  logic               rst,
  output logic               rqi_p,
  input  logic               aki_n,
  input  logic [INSTR_W-1:0] cmd_n,
  output logic [7:0]         jadr_p,
  input  logic [UADR_W-1:0]  jdat_n,
  output logic [UADR_W-1:0]  uadr_p,
  input  logic [UOP_W-1:0]   udat_n,
  output logic               uop_vld,
  output logic [UOP_W-1:0]   uop,
  output logic [INSTR_W-1:0] instr,
  input  logic               exe_rdy,
  input  logic               flush
);

  dec_state_t         state, state_nxt;
  logic [7:0]         jadr_q, jadr_nxt;
  logic [UADR_W-1:0]  uadr_q, uadr_nxt;
  logic [INSTR_W-1:0] instr_nxt;
  logic [INSTR_W-1:0] buf_data;
  logic               buf_vld, direct, drain, load_instr, load_uop;

  decoder_pfbuf #(.INSTR_W(INSTR_W)) u_pfbuf (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_fetch (state == FETCH),
    .aki_n    (aki_n),
    .cmd_n    (cmd_n),
    .drain    (drain),
    .rqi_p    (rqi_p),
    .direct   (direct),
    .buf_vld  (buf_vld),
    .buf_data (buf_data)
  );

  // ROM addresses are presented as next-state values so the registered ROMs
  // return their data in the following cycle.
  assign jadr_p  = jadr_nxt;
  assign uadr_p  = uadr_nxt;
  assign uop_vld = (state == ISSUE);

  always_comb begin
    state_nxt  = state;
    jadr_nxt   = jadr_q;
    uadr_nxt   = uadr_q;
    instr_nxt  = buf_data;
    drain      = 1'b0;
    load_instr = 1'b0;
    load_uop   = 1'b0;
    if (rst) begin
      state_nxt = FETCH;
      jadr_nxt  = '0;
      uadr_nxt  = '0;
    end else if (flush) begin
      state_nxt = FETCH;
    end else begin
      case (state)
        FETCH: begin
          if (buf_vld) begin
            drain      = 1'b1;
            load_instr = 1'b1;
            jadr_nxt   = opcode_of(buf_data[INSTR_W-1 -: 16]);
            state_nxt  = JUMP;
          end else if (direct) begin
            load_instr = 1'b1;
            instr_nxt  = cmd_n;
            jadr_nxt   = opcode_of(cmd_n[INSTR_W-1 -: 16]);
            state_nxt  = JUMP;
          end
        end
        JUMP: begin
          uadr_nxt  = jdat_n;
          state_nxt = ULOAD;
        end
        ULOAD: begin
          load_uop  = 1'b1;
          state_nxt = ISSUE;
        end
        ISSUE: begin
          if (exe_rdy) begin
            if (uop[EOL_BIT]) begin
              if (buf_vld) begin
                drain      = 1'b1;
                load_instr = 1'b1;
                jadr_nxt   = opcode_of(buf_data[INSTR_W-1 -: 16]);
                state_nxt  = JUMP;
              end else begin
                state_nxt = FETCH;
              end
            end else begin
              uadr_nxt  = uop[BR_BIT] ? uop[BR_LSB +: UADR_W] : UADR_W'(uadr_q + 1'b1);
              state_nxt = ULOAD;
            end
          end
        end
        default: state_nxt = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= FETCH;
      jadr_q <= '0;
      uadr_q <= '0;
      instr  <= '0;
      uop    <= '0;
    end else begin
      state  <= state_nxt;
      jadr_q <= jadr_nxt;
      uadr_q <= uadr_nxt;
      if (load_instr)
        instr <= instr_nxt;
      if (load_uop)
        uop <= udat_n;
    end
  end

endmodule

// File: tb/tb_decoder_seq.sv
// Directed bench for decoder_seq with behavioural registered jump and microcode ROMs.
module tb_decoder_seq;

  logic        clk = 1'b0;
  logic        rst, aki_n, exe_rdy, flush;
  logic [31:0] cmd_n;
  logic        rqi_p, uop_vld;
  logic [7:0]  jadr_p, jdat_n, uadr_p;
  logic [15:0] udat_n, uop;
  logic [31:0] instr;

  logic [7:0]  jrom [256];
  logic [15:0] urom [256];

  int errors = 0;
  int checks = 0;

  localparam logic [31:0] INS_A = 32'h1234_0000;
  localparam logic [31:0] INS_B = 32'hC3A0_0000;
  localparam logic [31:0] INS_D = 32'hD4C0_0000;
  localparam logic [31:0] INS_E = 32'hE000_0000;

  decoder_seq dut (
    .clk     (clk),
    .rst     (rst),
    .rqi_p   (rqi_p),
    .aki_n   (aki_n),
    .cmd_n   (cmd_n),
    .jadr_p  (jadr_p),
    .jdat_n  (jdat_n),
    .uadr_p  (uadr_p),
    .udat_n  (udat_n),
    .uop_vld (uop_vld),
    .uop     (uop),
    .instr   (instr),
    .exe_rdy (exe_rdy),
    .flush   (flush)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    jdat_n <= jrom[jadr_p];
    udat_n <= urom[uadr_p];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept one instruction from FETCH and advance to the first ISSUE cycle
  task automatic run_to_issue(input logic [31:0] w);
    aki_n = 1'b1;
    cmd_n = w;
    step();
    aki_n = 1'b0;
    step();
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; aki_n = 1'b0; exe_rdy = 1'b0; flush = 1'b0; cmd_n = '0;
    step();
    step();
    checks++; if (rqi_p !== 1'b0) begin errors++; $display("FAIL rst_rqi_during: got %b want 0", rqi_p); end
    rst = 1'b0;
    #1;
    checks++; if (rqi_p !== 1'b1) begin errors++; $display("FAIL rst_rqi_after: got %b want 1", rqi_p); end
    checks++; if ({uop_vld, uop, instr, uadr_p, jadr_p} !== 65'd0) begin
      errors++; $display("FAIL rst_values: vld=%b uop=%h instr=%h uadr=%h jadr=%h want all 0", uop_vld, uop, instr, uadr_p, jadr_p);
    end
  endtask

  task automatic test_basic();
    aki_n = 1'b1; cmd_n = INS_A;
    #1;
    checks++; if (jadr_p !== 8'h18) begin errors++; $display("FAIL basic_jadr: got %h want 18", jadr_p); end
    step();
    aki_n = 1'b0;
    #1;
    checks++; if (uadr_p !== 8'h20 || uop_vld !== 1'b0 || rqi_p !== 1'b1) begin
      errors++; $display("FAIL basic_jump: uadr=%h vld=%b rqi=%b want 20 0 1", uadr_p, uop_vld, rqi_p);
    end
    step();
    checks++; if (uop_vld !== 1'b0) begin errors++; $display("FAIL basic_uload_vld: got %b want 0", uop_vld); end
    step();
    checks++; if (uop_vld !== 1'b1 || uop !== 16'h0011 || instr !== INS_A) begin
      errors++; $display("FAIL basic_issue: vld=%b uop=%h instr=%h want 1 0011 %h", uop_vld, uop, instr, INS_A);
    end
    exe_rdy = 1'b1;
    step();
    exe_rdy = 1'b0;
    checks++; if (uop_vld !== 1'b0 || rqi_p !== 1'b1) begin
      errors++; $display("FAIL basic_done: vld=%b rqi=%b want 0 1", uop_vld, rqi_p);
    end
  endtask

  task automatic test_branch();
    aki_n = 1'b1; cmd_n = INS_D;
    #1;
    checks++; if (jadr_p !== 8'hD7) begin errors++; $display("FAIL br_jadr: got %h want d7", jadr_p); end
    step();
    aki_n = 1'b0;
    #1;
    checks++; if (uadr_p !== 8'h30) begin errors++; $display("FAIL br_uadr0: got %h want 30", uadr_p); end
    step();
    step();
    checks++; if (uop_vld !== 1'b1 || uop !== 16'h5021) begin
      errors++; $display("FAIL br_uop0: vld=%b uop=%h want 1 5021", uop_vld, uop);
    end
    exe_rdy = 1'b1;
    #1;
    checks++; if (uadr_p !== 8'h50) begin errors++; $display("FAIL br_uadr1: got %h want 50", uadr_p); end
    step();
    exe_rdy = 1'b0;
    checks++; if (uop_vld !== 1'b0) begin errors++; $display("FAIL br_uload_vld: got %b want 0", uop_vld); end
    step();
    checks++; if (uop_vld !== 1'b1 || uop !== 16'h0012 || instr !== INS_D) begin
      errors++; $display("FAIL br_uop1: vld=%b uop=%h instr=%h want 1 0012 %h", uop_vld, uop, instr, INS_D);
    end
    exe_rdy = 1'b1;
    step();
    exe_rdy = 1'b0;
    checks++; if (uop_vld !== 1'b0) begin errors++; $display("FAIL br_done: got %b want 0", uop_vld); end
  endtask

  task automatic test_stall();
    run_to_issue(INS_A);
    for (int i = 0; i < 5; i++) begin
      checks++; if (uop_vld !== 1'b1 || uop !== 16'h0011 || instr !== INS_A) begin
        errors++; $display("FAIL stall_hold%0d: vld=%b uop=%h instr=%h want 1 0011 %h", i, uop_vld, uop, instr, INS_A);
      end
      step();
    end
    exe_rdy = 1'b1;
    step();
    exe_rdy = 1'b0;
    checks++; if (uop_vld !== 1'b0) begin errors++; $display("FAIL stall_release: got %b want 0", uop_vld); end
  endtask

  task automatic test_back_to_back();
    aki_n = 1'b1; cmd_n = INS_A;
    step();
    cmd_n = INS_B;
    #1;
    checks++; if (rqi_p !== 1'b1) begin errors++; $display("FAIL b2b_rqi_empty: got %b want 1", rqi_p); end
    step();
    aki_n = 1'b0;
    #1;
    checks++; if (rqi_p !== 1'b0) begin errors++; $display("FAIL b2b_rqi_full: got %b want 0", rqi_p); end
    step();
    exe_rdy = 1'b1;
    #1;
    checks++; if (jadr_p !== 8'hCA) begin errors++; $display("FAIL b2b_jadr: got %h want ca", jadr_p); end
    step();
    exe_rdy = 1'b0;
    #1;
    checks++; if (uop_vld !== 1'b0 || uadr_p !== 8'h40 || instr !== INS_B) begin
      errors++; $display("FAIL b2b_jump: vld=%b uadr=%h instr=%h want 0 40 %h", uop_vld, uadr_p, instr, INS_B);
    end
    step();
    step();
    checks++; if (uop_vld !== 1'b1 || uop !== 16'h0013 || instr !== INS_B) begin
      errors++; $display("FAIL b2b_issue: vld=%b uop=%h instr=%h want 1 0013 %h", uop_vld, uop, instr, INS_B);
    end
    exe_rdy = 1'b1;
    step();
    exe_rdy = 1'b0;
  endtask

  task automatic test_flush();
    aki_n = 1'b1; cmd_n = INS_A;
    step();
    aki_n = 1'b0;
    step();
    flush = 1'b1; aki_n = 1'b1; cmd_n = INS_B;
    step();
    flush = 1'b0; aki_n = 1'b0;
    #1;
    checks++; if (uop_vld !== 1'b0 || rqi_p !== 1'b1) begin
      errors++; $display("FAIL flush_next: vld=%b rqi=%b want 0 1", uop_vld, rqi_p);
    end
    // An idle FETCH with an empty buffer keeps the old jump address and never issues
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (uop_vld !== 1'b0 || jadr_p !== 8'h18) begin
        errors++; $display("FAIL flush_idle%0d: vld=%b jadr=%h want 0 18", i, uop_vld, jadr_p);
      end
    end
  endtask

  task automatic test_wrap_and_reset();
    run_to_issue(INS_E);
    checks++; if (uop !== 16'h0001) begin errors++; $display("FAIL wrap_uop: got %h want 0001", uop); end
    exe_rdy = 1'b1;
    #1;
    checks++; if (uadr_p !== 8'h00) begin errors++; $display("FAIL wrap_uadr: got %h want 00", uadr_p); end
    step();
    exe_rdy = 1'b0;
    step();
    checks++; if (uop_vld !== 1'b1 || uop !== 16'h0014) begin
      errors++; $display("FAIL wrap_issue: vld=%b uop=%h want 1 0014", uop_vld, uop);
    end
    rst = 1'b1;
    #1;
    checks++; if (rqi_p !== 1'b0) begin errors++; $display("FAIL mid_rst_rqi: got %b want 0", rqi_p); end
    step();
    rst = 1'b0;
    #1;
    checks++; if ({uop_vld, uop, instr, uadr_p, jadr_p} !== 65'd0 || rqi_p !== 1'b1) begin
      errors++; $display("FAIL mid_rst_values: vld=%b uop=%h instr=%h uadr=%h jadr=%h rqi=%b want 0s and rqi 1",
                         uop_vld, uop, instr, uadr_p, jadr_p, rqi_p);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (uop_vld !== 1'b0) begin errors++; $display("FAIL mid_rst_idle%0d: got %b want 0", i, uop_vld); end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      jrom[i] = 8'h00;
      urom[i] = 16'h0000;
    end
    jrom[8'h18] = 8'h20;
    jrom[8'hD7] = 8'h30;
    jrom[8'hCA] = 8'h40;
    jrom[8'hE0] = 8'hFF;
    urom[8'h20] = 16'h0011;
    urom[8'h30] = 16'h5021;
    urom[8'h50] = 16'h0012;
    urom[8'h40] = 16'h0013;
    urom[8'hFF] = 16'h0001;
    urom[8'h00] = 16'h0014;

    test_reset();
    test_basic();
    test_branch();
    test_stall();
    test_back_to_back();
    test_flush();
    test_wrap_and_reset();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
